// File: rtl/fft_stream_pkg.sv
// ----------------------------------------------------------------------------
// fft_stream_pkg
//   Shared definitions for the spectral streaming blocks: default frame and
//   sample sizes, the half-to-full rebuild state enum, and complex helpers.
//   Complex samples are packed {imag, real}; both halves are two's complement.
// ----------------------------------------------------------------------------
package fft_stream_pkg;

    localparam int unsigned FFT_LENGTH_DEF = 512;
    localparam int unsigned DATA_WIDTH_DEF = 48;
    localparam int unsigned HALF_DEF       = FFT_LENGTH_DEF / 2;
    localparam int unsigned COMP_WIDTH_DEF = DATA_WIDTH_DEF / 2;

    typedef enum logic [1:0] {
        StPass   = 2'd0,
        StNyq    = 2'd1,
        StMirror = 2'd2
    } state_t;

    typedef logic [DATA_WIDTH_DEF-1:0] cplx_t;

    // Negate a w-bit value held sign-extended in 64 bits; the most negative
    // w-bit value saturates to the most positive one instead of wrapping.
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x,
                                                   input int unsigned w);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (w - 1);
        if (x == -lim) begin
            return lim - 64'sd1;
        end
        return -x;
    endfunction

    // Saturating complex conjugate at the default sample width.
    function automatic cplx_t conj(input cplx_t x);
        return {COMP_WIDTH_DEF'(sat_neg(64'(signed'(x[DATA_WIDTH_DEF-1:COMP_WIDTH_DEF])),
                                        COMP_WIDTH_DEF)),
                x[COMP_WIDTH_DEF-1:0]};
    endfunction

endpackage

// File: rtl/half2full_buf.sv
// ----------------------------------------------------------------------------
// half2full_buf
//   Simple dual-port RAM holding one half-spectrum frame. One write port, one
//   synchronous read port (1-cycle latency). Contents are never reset so the
//   array maps onto block RAM.
//   Ports: aclk, we/waddr/wdata (write), raddr/rdata (registered read).
// ----------------------------------------------------------------------------
module half2full_buf #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 48,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/half2full_spectrum.sv
// ----------------------------------------------------------------------------
// half2full_spectrum
//   Rebuilds a full Hermitian FFT_LENGTH-bin frame from a HALF-bin half
//   spectrum: bins 0..HALF-1 pass through combinationally, bin HALF is zero,
//   bins HALF+1..FFT_LENGTH-1 are conj(X[FFT_LENGTH-k]) read back in reverse.
//   Ports: aclk, aresetn (async, active low); s_axis_* half-spectrum input;
//   m_axis_* full-spectrum output; err_tlast_early / err_tlast_missing are
//   one-cycle pulses flagging upstream tlast placement errors.
//   Build option: HALF2FULL_DC_REAL_EN forces the imag part of output bin 0
//   to zero (the buffer keeps the original sample).
// ----------------------------------------------------------------------------
module half2full_spectrum
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FFT_LENGTH = FFT_LENGTH_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing
);

    localparam int unsigned HALF = FFT_LENGTH / 2;
    localparam int unsigned AW   = $clog2(HALF);
    localparam int unsigned CW   = DATA_WIDTH / 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    state_t                 state_q;
    logic [AW-1:0]          in_cnt_q;
    logic [AW-1:0]          rd_ptr_q;
    logic                   run_q;
    logic                   s_hs;
    logic                   m_hs;
    logic [AW-1:0]          rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic signed [CW-1:0]   rd_imag;
    logic [CW-1:0]          mir_imag;

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    // Read address always points at the sample the output must show next
    // cycle: the RAM read register then doubles as the output holding stage,
    // re-reading the same address while the sink stalls.
    always_comb begin
        rd_addr = '0;
        unique case (state_q)
            StNyq:    rd_addr = LAST_IDX;
            StMirror: rd_addr = m_hs ? (rd_ptr_q - ONE_IDX) : rd_ptr_q;
            default:  rd_addr = '0;
        endcase
    end

    half2full_buf #(
        .DEPTH (HALF),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .aclk  (aclk),
        .we    (s_hs),
        .waddr (in_cnt_q),
        .wdata (s_axis_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rd_imag  = rd_data[DATA_WIDTH-1:CW];
    assign mir_imag = CW'(sat_neg(64'(rd_imag), CW));

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        unique case (state_q)
            StPass: begin
                s_axis_tready = m_axis_tready & run_q;
                m_axis_tvalid = s_axis_tvalid & run_q;
                m_axis_tdata  = run_q ? s_axis_tdata : '0;
`ifdef HALF2FULL_DC_REAL_EN
                if (in_cnt_q == '0) begin
                    m_axis_tdata[DATA_WIDTH-1:CW] = '0;
                end
`else
                // Bin 0 is forwarded untouched.
`endif
            end
            StNyq: begin
                m_axis_tvalid = 1'b1;
            end
            StMirror: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {mir_imag, rd_data[CW-1:0]};
                m_axis_tlast  = (rd_ptr_q == ONE_IDX);
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // Framing is by count only; tlast is merely checked against the count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q           <= StPass;
            in_cnt_q          <= '0;
            rd_ptr_q          <= '0;
            run_q             <= 1'b0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
        end else begin
            run_q             <= 1'b1;
            err_tlast_early   <= s_hs & s_axis_tlast & (in_cnt_q != LAST_IDX);
            err_tlast_missing <= s_hs & ~s_axis_tlast & (in_cnt_q == LAST_IDX);
            unique case (state_q)
                StPass: begin
                    if (s_hs) begin
                        if (in_cnt_q == LAST_IDX) begin
                            in_cnt_q <= '0;
                            state_q  <= StNyq;
                        end else begin
                            in_cnt_q <= in_cnt_q + ONE_IDX;
                        end
                    end
                end
                StNyq: begin
                    if (m_hs) begin
                        rd_ptr_q <= LAST_IDX;
                        state_q  <= StMirror;
                    end
                end
                StMirror: begin
                    if (m_hs) begin
                        rd_ptr_q <= rd_ptr_q - ONE_IDX;
                        if (rd_ptr_q == ONE_IDX) begin
                            state_q <= StPass;
                        end
                    end
                end
                default: begin
                    state_q <= StPass;
                end
            endcase
        end
    end

endmodule
